// File: rtl/dvp_gray_conv.sv
// RGB565 camera stream to 8-bit luminance with a 3-stage pipeline, pixel coordinates
// and frame-geometry checking. Output is gated until the first frame sync after reset.
module dvp_gray_conv #(
    parameter int H_ACT = 640,
    parameter int V_ACT = 480
) (
    input  logic        ov5640_pclk,
    input  logic        rst,
    input  logic        dvp_vsync,
    input  logic        dvp_href,
    input  logic        dvp_valid,
    input  logic [15:0] dvp_data,
    output logic        gray_vsync,
    output logic        gray_href,
    output logic        gray_valid,
    output logic [7:0]  gray_data,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        frame_done,
    output logic        size_err
);

    typedef enum logic {WAIT_SYNC, ACTIVE} state_t;

    localparam logic [10:0] PIX_MAX = 11'd2047;
    localparam logic [10:0] H_LEN   = 11'(H_ACT);
    localparam logic [10:0] V_LEN   = 11'(V_ACT);

    state_t      r_state;
    state_t      w_stateNext;

    logic [7:0]  w_r8;
    logic [7:0]  w_g8;
    logic [7:0]  w_b8;
    logic [15:0] r_prodR;
    logic [15:0] r_prodG;
    logic [15:0] r_prodB;
    logic [15:0] r_sum;
    logic [7:0]  r_grayData;

    logic        r_vs1, r_vs2, r_vs3, r_vs4;
    logic        r_hr1, r_hr2, r_hr3, r_hr4;
    logic        r_va1, r_va2, r_va3;

    logic [10:0] r_pixX;
    logic [10:0] r_pixY;
    logic [10:0] w_linesDone;
    logic        r_frameDone;
    logic        r_sizeErr;

    logic        w_vsRise;
    logic        w_hrFall;
    logic        w_lineEnd;
    logic        w_frameEnd;

    assign w_r8 = {dvp_data[15:11], dvp_data[15:13]};
    assign w_g8 = {dvp_data[10:5],  dvp_data[10:9]};
    assign w_b8 = {dvp_data[4:0],   dvp_data[4:2]};

    // Edges are taken on the delayed controls so they line up with stage-3 data
    assign w_vsRise   = r_vs3 & ~r_vs4;
    assign w_hrFall   = ~r_hr3 & r_hr4;
    assign w_lineEnd  = w_hrFall && (r_pixX != 11'd0);
    assign w_frameEnd = (r_state == ACTIVE) && w_vsRise && (r_pixY != 11'd0);
    assign w_linesDone = (w_lineEnd && (r_pixY != PIX_MAX)) ? r_pixY + 11'd1 : r_pixY;

    always_ff @(posedge ov5640_pclk) begin
        if (rst) begin
            r_prodR    <= '0;
            r_prodG    <= '0;
            r_prodB    <= '0;
            r_sum      <= '0;
            r_grayData <= '0;
            r_vs1 <= 1'b0; r_vs2 <= 1'b0; r_vs3 <= 1'b0; r_vs4 <= 1'b0;
            r_hr1 <= 1'b0; r_hr2 <= 1'b0; r_hr3 <= 1'b0; r_hr4 <= 1'b0;
            r_va1 <= 1'b0; r_va2 <= 1'b0; r_va3 <= 1'b0;
        end else begin
            r_prodR <= 16'(w_r8) * 16'd77;
            r_prodG <= 16'(w_g8) * 16'd150;
            r_prodB <= 16'(w_b8) * 16'd29;
            r_sum   <= r_prodR + r_prodG + r_prodB + 16'd128;
            // Only pixels that will actually be emitted may change the held value
            if (r_va2 && (w_stateNext == ACTIVE)) begin
                r_grayData <= 8'(r_sum >> 8);
            end
            r_vs1 <= dvp_vsync; r_vs2 <= r_vs1; r_vs3 <= r_vs2; r_vs4 <= r_vs3;
            r_hr1 <= dvp_href;  r_hr2 <= r_hr1; r_hr3 <= r_hr2; r_hr4 <= r_hr3;
            r_va1 <= dvp_valid; r_va2 <= r_va1; r_va3 <= r_va2;
        end
    end

    always_ff @(posedge ov5640_pclk) begin
        if (rst) begin
            r_state <= WAIT_SYNC;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        gray_vsync  = 1'b0;
        gray_href   = 1'b0;
        gray_valid  = 1'b0;
        case (r_state)
            WAIT_SYNC: begin
                if (w_vsRise) begin
                    w_stateNext = ACTIVE;
                end
            end
            ACTIVE: begin
                gray_vsync = r_vs3;
                gray_href  = r_hr3;
                gray_valid = r_va3;
            end
            default: w_stateNext = WAIT_SYNC;
        endcase
    end

    // A coincident frame sync clears the row but the closing line is still length-checked
    always_ff @(posedge ov5640_pclk) begin
        if (rst) begin
            r_pixX      <= '0;
            r_pixY      <= '0;
            r_frameDone <= 1'b0;
            r_sizeErr   <= 1'b0;
        end else begin
            if (w_hrFall) begin
                r_pixX <= '0;
            end else if (gray_valid && (r_pixX != PIX_MAX)) begin
                r_pixX <= r_pixX + 11'd1;
            end

            if (w_vsRise) begin
                r_pixY <= '0;
            end else begin
                r_pixY <= w_linesDone;
            end

            r_frameDone <= w_frameEnd;

            if (w_lineEnd && (r_pixX != H_LEN)) begin
                r_sizeErr <= 1'b1;
            end
            if (w_frameEnd && (w_linesDone != V_LEN)) begin
                r_sizeErr <= 1'b1;
            end
        end
    end

    assign gray_data  = r_grayData;
    assign pix_x      = r_pixX;
    assign pix_y      = r_pixY;
    assign frame_done = r_frameDone;
    assign size_err   = r_sizeErr;

endmodule

// File: tb/tb_dvp_gray_conv.sv
// Directed bench for dvp_gray_conv with a 4x2 frame: colour points, geometry,
// size errors, startup gating, mid-frame reset and vsync/href edge coincidence.
module tb_dvp_gray_conv;

    logic        clk;
    logic        rst;
    logic        dvp_vsync;
    logic        dvp_href;
    logic        dvp_valid;
    logic [15:0] dvp_data;
    logic        gray_vsync;
    logic        gray_href;
    logic        gray_valid;
    logic [7:0]  gray_data;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic        frame_done;
    logic        size_err;

    int vectors     = 0;
    int miscompares = 0;
    int fdCount     = 0;

    logic [3:0][15:0] lineA;
    logic [3:0][7:0]  expA;
    logic [3:0][15:0] lineB;
    logic [3:0][7:0]  expB;

    dvp_gray_conv #(.H_ACT(4), .V_ACT(2)) dut (
        .ov5640_pclk (clk),
        .rst         (rst),
        .dvp_vsync   (dvp_vsync),
        .dvp_href    (dvp_href),
        .dvp_valid   (dvp_valid),
        .dvp_data    (dvp_data),
        .gray_vsync  (gray_vsync),
        .gray_href   (gray_href),
        .gray_valid  (gray_valid),
        .gray_data   (gray_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_done  (frame_done),
        .size_err    (size_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample 1 time unit after the edge that consumed them
    task automatic applyStimulus(input logic vs, input logic hr, input logic va, input logic [15:0] d);
        dvp_vsync = vs;
        dvp_href  = hr;
        dvp_valid = va;
        dvp_data  = d;
        @(posedge clk);
        #1;
        if (frame_done === 1'b1) fdCount++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sendLine(input int n, input logic [3:0][15:0] px, input logic [3:0][7:0] ex,
                            input int row, input logic expErr);
        for (int k = 0; k < n + 4; k++) begin
            if (k < n) applyStimulus(1'b0, 1'b1, 1'b1, px[k]);
            else       applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
            if (k >= 2 && k - 2 < n) begin
                checkOutput("gray_valid", 32'(gray_valid), 32'd1);
                checkOutput("gray_href",  32'(gray_href),  32'd1);
                checkOutput("gray_data",  32'(gray_data),  32'(ex[k-2]));
                checkOutput("pix_x",      32'(pix_x),      32'(k - 2));
                checkOutput("pix_y",      32'(pix_y),      32'(row));
            end
            if (k == n + 2) checkOutput("gray_valid_end", 32'(gray_valid), 32'd0);
        end
        checkOutput("gray_data_hold", 32'(gray_data), 32'(ex[n-1]));
        checkOutput("pix_x_line_end", 32'(pix_x),     32'd0);
        checkOutput("pix_y_line_end", 32'(pix_y),     32'(row + 1));
        checkOutput("size_err_line",  32'(size_err),  32'(expErr));
    endtask

    task automatic vsyncPulse(input logic expVs, input logic expFd, input logic expErr);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput("gray_vsync", 32'(gray_vsync), 32'(expVs));
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput("frame_done",     32'(frame_done), 32'(expFd));
        checkOutput("pix_y_vs",       32'(pix_y),      32'd0);
        checkOutput("size_err_frame", 32'(size_err),   32'(expErr));
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput("frame_done_one_cycle", 32'(frame_done), 32'd0);
    endtask

    initial begin
        lineA = {16'h07E0, 16'hF800, 16'h0000, 16'hFFFF};
        expA  = {8'd149,   8'd77,    8'd0,     8'd255};
        lineB = {16'h0000, 16'hFFFF, 16'h8410, 16'h001F};
        expB  = {8'd0,     8'd255,   8'd131,   8'd29};

        // Reset state
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput("rst_gray_valid", 32'(gray_valid), 32'd0);
        checkOutput("rst_gray_data",  32'(gray_data),  32'd0);
        checkOutput("rst_pix_x",      32'(pix_x),      32'd0);
        checkOutput("rst_pix_y",      32'(pix_y),      32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst_size_err",   32'(size_err),   32'd0);
        checkOutput("rst_gray_vsync", 32'(gray_vsync), 32'd0);
        checkOutput("rst_gray_href",  32'(gray_href),  32'd0);
        rst = 1'b0;

        // Pixels before the first frame sync are suppressed
        applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFF);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'hF800);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h07E0);
        checkOutput("gate_gray_valid", 32'(gray_valid), 32'd0);
        checkOutput("gate_gray_href",  32'(gray_href),  32'd0);
        checkOutput("gate_gray_data",  32'(gray_data),  32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput("gate_pix_y",    32'(pix_y),    32'd0);
        checkOutput("gate_size_err", 32'(size_err), 32'd0);

        // First sync only arms the output
        vsyncPulse(1'b0, 1'b0, 1'b0);
        checkOutput("fd_count_first_sync", 32'(fdCount), 32'd0);

        // Geometry frame carrying the colour points
        sendLine(4, lineA, expA, 0, 1'b0);
        sendLine(4, lineB, expB, 1, 1'b0);
        checkOutput("pix_y_after_frame", 32'(pix_y), 32'd2);
        vsyncPulse(1'b1, 1'b1, 1'b0);
        checkOutput("fd_count_geometry", 32'(fdCount), 32'd1);

        // href without any valid is not a line
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput("empty_line_pix_y",    32'(pix_y),    32'd0);
        checkOutput("empty_line_size_err", 32'(size_err), 32'd0);

        // Short second line sets the sticky error, which survives a good frame
        sendLine(4, lineA, expA, 0, 1'b0);
        sendLine(3, lineB, expB, 1, 1'b1);
        vsyncPulse(1'b1, 1'b1, 1'b1);
        sendLine(4, lineA, expA, 0, 1'b1);
        sendLine(4, lineB, expB, 1, 1'b1);
        vsyncPulse(1'b1, 1'b1, 1'b1);

        // Reset in the middle of the second line
        sendLine(4, lineA, expA, 0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, lineB[0]);
        applyStimulus(1'b0, 1'b1, 1'b1, lineB[1]);
        applyStimulus(1'b0, 1'b1, 1'b1, lineB[2]);
        checkOutput("pre_rst_gray_valid", 32'(gray_valid), 32'd1);
        checkOutput("pre_rst_gray_data",  32'(gray_data),  32'd29);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1, lineB[3]);
        rst = 1'b0;
        checkOutput("midrst_gray_valid", 32'(gray_valid), 32'd0);
        checkOutput("midrst_gray_href",  32'(gray_href),  32'd0);
        checkOutput("midrst_gray_data",  32'(gray_data),  32'd0);
        checkOutput("midrst_pix_x",      32'(pix_x),      32'd0);
        checkOutput("midrst_pix_y",      32'(pix_y),      32'd0);
        checkOutput("midrst_size_err",   32'(size_err),   32'd0);
        checkOutput("midrst_frame_done", 32'(frame_done), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFF);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFF);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
            checkOutput("post_rst_gray_valid", 32'(gray_valid), 32'd0);
        end
        checkOutput("post_rst_pix_y", 32'(pix_y), 32'd0);
        vsyncPulse(1'b0, 1'b0, 1'b0);
        sendLine(4, lineA, expA, 0, 1'b0);

        // vsync rise coincides with the href fall of a 3-pixel line
        applyStimulus(1'b0, 1'b1, 1'b1, lineA[0]);
        applyStimulus(1'b0, 1'b1, 1'b1, lineA[1]);
        applyStimulus(1'b0, 1'b1, 1'b1, lineA[2]);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput("coinc_pix_y",      32'(pix_y),      32'd0);
        checkOutput("coinc_pix_x",      32'(pix_x),      32'd0);
        checkOutput("coinc_size_err",   32'(size_err),   32'd1);
        checkOutput("coinc_frame_done", 32'(frame_done), 32'd1);
        checkOutput("coinc_gray_data",  32'(gray_data),  32'd77);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput("coinc_frame_done_off", 32'(frame_done), 32'd0);
        checkOutput("fd_count_total",       32'(fdCount),    32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
